// File: rtl/ga22_sdr_responder_if.sv
// Bundles the sprite-renderer fetch port and the SDRAM controller channel.
// The responder uses the slave view; the renderer/controller side uses master.
interface ga22_sdr_responder_if #(
    parameter int ADDR_W = 25
);
    logic              sdr_req;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_refresh;
    logic [63:0]       sdr_data;
    logic              sdr_rdy;
    logic              inv;
    logic [ADDR_W-2:0] ch_addr;
    logic              ch_req;
    logic              ch_ack;
    logic              ch_valid;
    logic [15:0]       ch_data;
    logic              ref_req;
    logic              ref_ack;

    modport slave (
        input  sdr_req, sdr_addr, sdr_refresh, inv, ch_ack, ch_valid, ch_data, ref_ack,
        output sdr_data, sdr_rdy, ch_addr, ch_req, ref_req
    );

    modport master (
        output sdr_req, sdr_addr, sdr_refresh, inv, ch_ack, ch_valid, ch_data, ref_ack,
        input  sdr_data, sdr_rdy, ch_addr, ch_req, ref_req
    );
endinterface

// File: rtl/ga22_sdr_responder.sv
// Sprite-renderer SDRAM fetch responder: turns each 64-bit fetch into a
// 4-beat 16-bit burst, assembles the beats, keeps a one-entry last-address
// cache and forwards idle-time refresh requests.
module ga22_sdr_responder #(
    parameter int ADDR_W   = 25,
    parameter int BEATS    = 4,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    ga22_sdr_responder_if.slave  bus
);
    localparam int TAG_W = ADDR_W - 3;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] REFRESH = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pend_v_q, pend_v_d;
    logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic              inv_seen_q, inv_seen_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic [47:0]       asm_q, asm_d;
    logic [63:0]       data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              ch_req_q, ch_req_d;
    logic [ADDR_W-2:0] ch_addr_q, ch_addr_d;
    logic              ref_req_q, ref_req_d;

    logic              have_req;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              unused_addr_lsb;

    // A request arriving this cycle overrides (and replaces) the pended one.
    assign have_req        = pend_v_q | bus.sdr_req;
    assign req_tag         = bus.sdr_req ? bus.sdr_addr[ADDR_W-1:3] : pend_tag_q;
    assign hit             = CACHE_EN && valid_q && (tag_q == req_tag) && !bus.inv;
    assign unused_addr_lsb = ^bus.sdr_addr[2:0];

    assign bus.sdr_data = data_q;
    assign bus.sdr_rdy  = rdy_q;
    assign bus.ch_addr  = ch_addr_q;
    assign bus.ch_req   = ch_req_q;
    assign bus.ref_req  = ref_req_q;

    // Next-state logic: request capture, cache invalidation and the fetch FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_v_d   = pend_v_q;
        pend_tag_d = pend_tag_q;
        cur_tag_d  = cur_tag_q;
        inv_seen_d = inv_seen_q | bus.inv;
        tag_d      = tag_q;
        valid_d    = valid_q & ~bus.inv;
        asm_d      = asm_q;
        data_d     = data_q;
        rdy_d      = 1'b0;
        ch_req_d   = ch_req_q;
        ch_addr_d  = ch_addr_q;
        ref_req_d  = ref_req_q;

        if (bus.sdr_req) begin
            pend_v_d   = 1'b1;
            pend_tag_d = bus.sdr_addr[ADDR_W-1:3];
        end

        case (state_q)
            IDLE: begin
                if (have_req) begin
                    pend_v_d   = 1'b0;
                    cur_tag_d  = req_tag;
                    inv_seen_d = bus.inv;
                    if (hit) begin
                        // sdr_data already holds this word
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        ch_req_d  = 1'b1;
                        ch_addr_d = {req_tag, 2'b00};
                        state_d   = REQ;
                    end
                end else if (bus.sdr_refresh) begin
                    ref_req_d = 1'b1;
                    state_d   = REFRESH;
                end
            end
            REQ: begin
                if (bus.ch_ack) begin
                    ch_req_d = 1'b0;
                    cnt_d    = 2'd0;
                    state_d  = DATA;
                    // controller may deliver beat0 together with the ack
                    if (bus.ch_valid) begin
                        asm_d[15:0] = bus.ch_data;
                        cnt_d       = 2'd1;
                    end
                end
            end
            DATA: begin
                if (bus.ch_valid) begin
                    if (cnt_q == 2'(BEATS - 1)) begin
                        // last beat goes straight to the output word
                        data_d  = {bus.ch_data, asm_q};
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        asm_d[{cnt_q, 4'b0000} +: 16] = bus.ch_data;
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            DONE: begin
                tag_d   = cur_tag_q;
                valid_d = !inv_seen_q && !bus.inv;
                state_d = IDLE;
            end
            REFRESH: begin
                if (bus.ref_ack) begin
                    ref_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_tag_q <= '0;
            cur_tag_q  <= '0;
            inv_seen_q <= 1'b0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            asm_q      <= '0;
            data_q     <= '0;
            rdy_q      <= 1'b0;
            ch_req_q   <= 1'b0;
            ch_addr_q  <= '0;
            ref_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pend_tag_q <= pend_tag_d;
            cur_tag_q  <= cur_tag_d;
            inv_seen_q <= inv_seen_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            ch_req_q   <= ch_req_d;
            ch_addr_q  <= ch_addr_d;
            ref_req_q  <= ref_req_d;
        end
    end
endmodule
